// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between the CPU and N_REQ score requesters.
// The CPU always wins; pending per-requester increments are injected round-robin on idle cycles.
module rf_write_arbiter #(
   parameter int N_REQ        = 4,
   parameter int AMT_W        = 3,
   parameter int PEND_W       = 8,
   parameter int BASE_REG     = 26,
   parameter int STARVE_LIMIT = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cpu_we,
   input  logic [4:0]               cpu_rd,
   input  logic [31:0]              cpu_data,
   input  logic [N_REQ-1:0]         inc_valid,
   input  logic [N_REQ*AMT_W-1:0]   inc_amt,
   output logic                     rf_we,
   output logic [4:0]               rf_rd,
   output logic [31:0]              rf_data,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         pending_nz,
   output logic [N_REQ-1:0]         overflow,
   output logic                     starve
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_LIMIT);

   logic [PEND_W-1:0] pend      [N_REQ];
   logic [PEND_W-1:0] pend_next [N_REQ];
   logic [N_REQ-1:0]  ovf_next;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  rr_next;
   logic [PTR_W-1:0]  sel;
   logic              any_pend;
   logic              inject;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  cnt_next;

   // Round-robin search starting at rr_ptr for the first nonzero accumulator.
   always_comb begin
      int idx;
      logic found;
      idx   = 0;
      found = 1'b0;
      sel   = rr_ptr;
      for (int i = 0; i < N_REQ; i++) begin
         pending_nz[i] = (pend[i] != '0);
      end
      any_pend = |pending_nz;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (!found && pending_nz[idx]) begin
            found = 1'b1;
            sel   = PTR_W'(idx);
         end
      end
      rr_next = PTR_W'((int'(sel) + 1) % N_REQ);
      inject  = !reset && !cpu_we && any_pend;
   end

   // Zero-latency port mux; reset forces the port quiet even if the CPU is writing.
   always_comb begin
      rf_we   = 1'b0;
      rf_rd   = '0;
      rf_data = '0;
      grant   = '0;
      if (!reset) begin
         if (cpu_we) begin
            rf_we   = 1'b1;
            rf_rd   = cpu_rd;
            rf_data = cpu_data;
         end else if (any_pend) begin
            rf_we      = 1'b1;
            rf_rd      = 5'(BASE_REG + int'(sel));
            rf_data    = 32'(pend[sel]);
            grant[sel] = 1'b1;
         end
      end
   end

   // A granted accumulator restarts from this cycle's increment so nothing is lost.
   always_comb begin
      logic [AMT_W-1:0]  amt;
      logic [PEND_W:0]   sum;
      amt = '0;
      sum = '0;
      for (int i = 0; i < N_REQ; i++) begin
         amt          = inc_amt[i*AMT_W +: AMT_W];
         sum          = {1'b0, pend[i]} + (PEND_W+1)'(amt);
         pend_next[i] = pend[i];
         ovf_next[i]  = 1'b0;
         if (grant[i]) begin
            pend_next[i] = inc_valid[i] ? PEND_W'(amt) : '0;
         end else if (inc_valid[i]) begin
            if (sum[PEND_W]) begin
               pend_next[i] = PEND_MAX;
               ovf_next[i]  = 1'b1;
            end else begin
               pend_next[i] = sum[PEND_W-1:0];
            end
         end
      end
   end

   always_comb begin
      cnt_next = starve_cnt;
      if (inject || !any_pend) begin
         cnt_next = '0;
      end else if (cpu_we && starve_cnt != CNT_MAX) begin
         cnt_next = starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_REQ; i++) begin
            pend[i] <= '0;
         end
         overflow   <= '0;
         rr_ptr     <= '0;
         starve_cnt <= '0;
         starve     <= 1'b0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            pend[i] <= pend_next[i];
         end
         overflow   <= ovf_next;
         starve_cnt <= cnt_next;
         starve     <= (cnt_next == CNT_MAX);
         if (inject) begin
            rr_ptr <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a behavioural model predicts each cycle's port outputs,
// a separate monitor pops and compares them.
module tb_rf_write_arbiter;

   localparam int N_REQ        = 4;
   localparam int AMT_W        = 3;
   localparam int PEND_W       = 8;
   localparam int BASE_REG     = 26;
   localparam int STARVE_LIMIT = 64;
   localparam int PEND_MAX     = (1 << PEND_W) - 1;

   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [3:0]  grant;
      logic [3:0]  pnz;
      logic [3:0]  ovf;
      logic        starve;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        cpu_we;
   logic [4:0]  cpu_rd;
   logic [31:0] cpu_data;
   logic [3:0]  inc_valid;
   logic [11:0] inc_amt;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data;
   logic [3:0]  grant;
   logic [3:0]  pending_nz;
   logic [3:0]  overflow;
   logic        starve;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 0;

   // Reference state: plain integers per requester, a rotating pointer and a busy-cycle count.
   int   m_pend[N_REQ];
   int   m_rr = 0;
   int   m_busy = 0;
   logic [3:0] m_ovf = '0;

   rf_write_arbiter #(
      .N_REQ(N_REQ), .AMT_W(AMT_W), .PEND_W(PEND_W),
      .BASE_REG(BASE_REG), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clock(clock), .reset(reset), .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_data(cpu_data),
      .inc_valid(inc_valid), .inc_amt(inc_amt), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
      .grant(grant), .pending_nz(pending_nz), .overflow(overflow), .starve(starve)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle of inputs shortly after the falling edge, predict the outputs, advance the model.
   task automatic applyStimulus(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                input logic [3:0] iv, input logic [11:0] amts, input logic rst);
      exp_t e;
      int   sel;
      int   a;
      int   s;
      bit   any;
      @(negedge clock);
      #1;
      reset     = rst;
      cpu_we    = we;
      cpu_rd    = rd;
      cpu_data  = data;
      inc_valid = iv;
      inc_amt   = amts;
      e   = '0;
      sel = -1;
      any = 0;
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) m_pend[i] = 0;
         m_rr   = 0;
         m_busy = 0;
         m_ovf  = '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            e.pnz[i] = (m_pend[i] != 0);
            if (m_pend[i] != 0) any = 1;
         end
         e.ovf    = m_ovf;
         e.starve = (m_busy == STARVE_LIMIT);
         if (we) begin
            e.we   = 1'b1;
            e.rd   = rd;
            e.data = data;
         end else if (any) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
               if (m_pend[(m_rr + k) % N_REQ] != 0) sel = (m_rr + k) % N_REQ;
            end
            e.we         = 1'b1;
            e.rd         = 5'(BASE_REG + sel);
            e.data       = 32'(m_pend[sel]);
            e.grant[sel] = 1'b1;
         end
         m_ovf = '0;
         for (int i = 0; i < N_REQ; i++) begin
            a = iv[i] ? int'(amts[i*AMT_W +: AMT_W]) : 0;
            if (i == sel) begin
               m_pend[i] = a;
            end else begin
               s = m_pend[i] + a;
               if (s > PEND_MAX) begin
                  m_pend[i] = PEND_MAX;
                  m_ovf[i]  = 1'b1;
               end else begin
                  m_pend[i] = s;
               end
            end
         end
         if (sel >= 0) m_rr = (sel + 1) % N_REQ;
         if (sel >= 0 || !any) m_busy = 0;
         else if (m_busy < STARVE_LIMIT) m_busy = m_busy + 1;
      end
      exp_q.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if ({rf_we, rf_rd, rf_data} !== {e.we, e.rd, e.data}) begin
         errors++;
         $display("[TB] FAIL rf_port t=%0t got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                  $time, rf_we, rf_rd, rf_data, e.we, e.rd, e.data);
      end
      checks++;
      if (grant !== e.grant) begin
         errors++;
         $display("[TB] FAIL grant t=%0t got %b want %b", $time, grant, e.grant);
      end
      checks++;
      if (pending_nz !== e.pnz) begin
         errors++;
         $display("[TB] FAIL pending_nz t=%0t got %b want %b", $time, pending_nz, e.pnz);
      end
      checks++;
      if (overflow !== e.ovf) begin
         errors++;
         $display("[TB] FAIL overflow t=%0t got %b want %b", $time, overflow, e.ovf);
      end
      checks++;
      if (starve !== e.starve) begin
         errors++;
         $display("[TB] FAIL starve t=%0t got %b want %b", $time, starve, e.starve);
      end
   endtask

   // Monitor: samples mid-low-phase, well clear of the rising edge, after the driver has settled.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      logic       we;
      logic [3:0] iv;
      for (int i = 0; i < N_REQ; i++) m_pend[i] = 0;
      reset = 1'b1; cpu_we = 1'b0; cpu_rd = '0; cpu_data = '0; inc_valid = '0; inc_amt = '0;
      applyStimulus(1'b1, 5'd3, 32'h1, 4'h0, 12'h0, 1'b1);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 1'b1);

      // Single increment injected on the next idle cycle.
      applyStimulus(1'b0, 5'd0, 32'h0, 4'b0100, 12'({3'd0, 3'd3, 3'd0, 3'd0}), 1'b0);
      repeat (2) applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 1'b0);

      // CPU busy while requester 0 accumulates 2+3+1.
      applyStimulus(1'b1, 5'd5, 32'hAA, 4'b0001, 12'd2, 1'b0);
      applyStimulus(1'b1, 5'd5, 32'hAA, 4'b0001, 12'd3, 1'b0);
      applyStimulus(1'b1, 5'd5, 32'hAA, 4'b0001, 12'd1, 1'b0);
      applyStimulus(1'b1, 5'd5, 32'hAA, 4'h0, 12'h0, 1'b0);
      repeat (2) applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 1'b0);

      // All four pending, then rotating grants with a fresh req0 increment mid-way.
      applyStimulus(1'b1, 5'd27, 32'h55, 4'hF, 12'({3'd4, 3'd3, 3'd2, 3'd1}), 1'b0);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 1'b0);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'b0001, 12'd6, 1'b0);
      repeat (4) applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 1'b0);

      // Increment arriving on the grant cycle of the same requester.
      applyStimulus(1'b1, 5'd1, 32'h1, 4'b0010, 12'({3'd0, 3'd0, 3'd2, 3'd0}), 1'b0);
      applyStimulus(1'b0, 5'd0, 32'h0, 4'b0010, 12'({3'd0, 3'd0, 3'd5, 3'd0}), 1'b0);
      repeat (2) applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 1'b0);

      // Saturation and starvation under a long CPU burst.
      for (int c = 0; c < 110; c++)
         applyStimulus(1'b1, 5'd9, 32'(c), (c < 40) ? 4'b0001 : 4'h0, 12'd7, 1'b0);
      repeat (2) applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 1'b0);

      // Asynchronous reset while a value is pending, then no inject afterwards.
      applyStimulus(1'b1, 5'd2, 32'h2, 4'b0100, 12'({3'd0, 3'd4, 3'd0, 3'd0}), 1'b0);
      applyStimulus(1'b1, 5'd2, 32'h2, 4'h0, 12'h0, 1'b1);
      repeat (2) applyStimulus(1'b0, 5'd0, 32'h0, 4'h0, 12'h0, 1'b0);

      for (int c = 0; c < 600; c++) begin
         we = ($urandom_range(0, 99) < ((c < 300) ? 40 : 85));
         iv = 4'($urandom) & 4'($urandom);
         applyStimulus(we, 5'($urandom), $urandom, iv, 12'($urandom),
                       ($urandom_range(0, 249) == 0));
      end
      stim_done = 1;
   end

   initial begin
      wait (stim_done);
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(negedge clock);
      repeat (2) @(negedge clock);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain got %0d entries left want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout got no end of stimulus want completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
